pipe_mips32_fwd: RTL and testbench
==================================

# pipe_mips32_fwd

Parametrised single-clock successor to the two-phase five-stage MIPS32 core (IF, ID, EX, MEM, WB), using the same instruction encoding and opcode map. It adds an asynchronous reset, operand forwarding, a load-use interlock, branch flush with correct BNEQZ/BEQZ polarity, retirement and stall counters, and a debug register read port. It is the core the team's directed program benches instantiate. Instruction and data memory is preloaded hierarchically.

## Interface
- DATA_W, 32: datapath and register width; instructions are always 32 bits.
- ADDR_W, 10: word-address width; memory depth is 2**ADDR_W.
- CNT_W, 16: width of the retired and stall counters.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous and active-high.
- halted  out  1  sticky; set when HLT reaches WB.
- pc  out  ADDR_W  current fetch address.
- retired  out  CNT_W  instructions completed in WB, including HLT.
- stalls  out  CNT_W  cycles in which ID was held for a data hazard.
- dbg_addr  in  5  register index for debug read.
- dbg_data  out  DATA_W  combinational Reg[dbg_addr]; reads 0 for index 0.
- Internal arrays Reg[0:31] and Mem[0:2**ADDR_W-1] are unified instruction/data memory, accessible hierarchically. Neither array is reset.

## Operation
- Encoding: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
  - Opcodes: ADD 0, SUB 1, AND 2, OR 3, SLT 4, MUL 5, LW 8, SW 9, ADDI 10, SUBI 11, SLTI 12, BNEQZ 13, BEQZ 14, HLT 63.
  - Any other opcode decodes as HLT.
- Destination register: rd for RR ops; rt for RM ops and LW. Writes to R0 are discarded, and R0 always reads 0.
- Immediate: sign-extended to DATA_W.
- Arithmetic: results keep the low DATA_W bits. MUL keeps the low half. SLT and SLTI are signed compares that return 0 or 1.
- Memory addresses: rs+imm truncated to ADDR_W bits, wrapping modulo depth.
- Reads: Mem is read combinationally in IF and MEM. SW writes at posedge in MEM and is visible to a fetch or load in the next cycle.
- Register file: write-first. A WB write is visible to an ID read in the same cycle.
- Branches resolve in EX; target = NPC + imm.
  - BEQZ is taken when rs == 0; BNEQZ is taken when rs != 0.
  - When taken: PC <= target, and the IF/ID and ID/EX contents are converted to bubbles. This costs 2 cycles, and squashed instructions have no side effects.
- Load-use hazard: LW in EX with its rt matching the ID instruction's rs/rt (nonzero) stalls ID for 1 cycle and inserts a bubble into EX.
- Halt sequence:
  - Once HLT is in ID, fetch freezes: PC holds and IF/ID receives bubbles.
  - Older instructions drain normally.
  - When HLT reaches WB, halted = 1 and all state freezes until rst.
- Counters: retired increments per valid non-bubble instruction in WB. stalls increments per hazard-stall cycle. Both saturate at all-ones.

## Timing
- Reset values: pc=0, halted=0, retired=0, stalls=0, all pipeline valid bits 0 (bubbles).
- Reset mid-operation discards the pipeline immediately. Reg and Mem keep their contents. Fetch of Mem[0] starts on the first posedge after rst deasserts.
- Latency: an instruction fetched at cycle n writes back at n+4 when it meets no hazard.
- Priority:
  1. rst
  2. halted freeze
  3. branch flush, which overrides any simultaneous stall
  4. hazard stall
  5. normal advance

## Configuration
- FORWARDING_EN defined:
  - EX operands forward from EX/MEM (ALU result) and MEM/WB (ALU result or load data), with the youngest source taking priority.
  - Only the load-use case stalls, for 1 cycle.
- FORWARDING_EN undefined:
  - No forwarding paths.
  - ID stalls while any valid EX or MEM instruction writes a nonzero register that matches ID's rs or rt.
  - Write-first register file resolves the WB case.
  - Back-to-back dependent ALU ops cost 2 stall cycles.

## Test plan
- Dependent ALU ops. Reg[k]=k, then ADD R3,R1,R2; ADD R4,R3,R3; HLT.
  - Required: R4=6, retired=3.
  - With FORWARDING_EN: stalls=0. Without it: stalls=2.
- Load-use. Mem[200]=7, Reg[10]=200, then LW R2,0(R10); ADD R3,R2,R2; HLT.
  - Required: R3=14, plus 1 stall with FORWARDING_EN or 2 without.
- Factorial loop. Mem[200]=7.
  - Program: ADDI R10,R0,200; ADDI R2,R0,1; LW R3,0(R10); MUL R2,R2,R3; SUBI R3,R3,1; BNEQZ R3,-3; SW R2,-2(R10); HLT.
  - Required: Mem[198]=5040, halted=1, R3=0.
- Branch flush. BEQZ R0,+2; ADDI R5,R0,9; ADDI R5,R0,9; ADDI R6,R0,3; HLT.
  - Required: R5 unchanged, R6=3, retired=3.
- Reset mid-run. Assert rst for 1 cycle during the factorial loop.
  - Required: pc=0, retired=0, halted=0 immediately.
  - After re-initialising Reg/Mem, the rerun produces Mem[198]=5040.
- R0 and illegal opcode. ADDI R0,R0,5; then opcode 6'b010101.
  - Required: dbg_addr=0 gives dbg_data=0, halted=1, retired=2.

Source files
------------

// File: rtl/pipe_mips32_fwd.sv
// pipe_mips32_fwd: five-stage MIPS32-subset core (IF/ID/EX/MEM/WB). Optional macro FORWARDING_EN adds EX bypass paths.
// Latency: fetch to writeback in 4 cycles without hazards; a taken branch costs 2 cycles, load-use 1 (bypass) or 2.
// Backpressure: none external; ID holds on data hazards, fetch freezes behind HLT, everything freezes once halted.
module pipe_mips32_fwd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired,
    output logic [CNT_W-1:0]  stalls,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'd63;

    typedef struct packed {
        logic              vld;
        logic [31:0]       ir;
        logic [ADDR_W-1:0] npc;
    } ifid_t;

    typedef struct packed {
        logic              vld;
        logic [5:0]        op;
`ifdef FORWARDING_EN
        logic [4:0]        rs;
        logic [4:0]        rt;
`endif
        logic [4:0]        dst;
        logic              wr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] npc;
    } idex_t;

    typedef struct packed {
        logic              vld;
        logic [5:0]        op;
        logic [4:0]        dst;
        logic              wr;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] b;
    } exmem_t;

    typedef struct packed {
        logic              vld;
        logic [5:0]        op;
        logic [4:0]        dst;
        logic              wr;
        logic [DATA_W-1:0] val;
    } memwb_t;

    // Architectural state; never reset, loaded hierarchically from outside.
    logic [DATA_W-1:0] Reg [0:31];
    logic [DATA_W-1:0] Mem [0:DEPTH-1];

    ifid_t  ifid;
    idex_t  idex;
    idex_t  id_pkt;
    exmem_t exmem;
    memwb_t memwb;

    logic [5:0]        id_op;
    logic [4:0]        id_rs, id_rt, id_rd, id_dst;
    logic              id_is_rr, id_is_rm, id_use_rs, id_use_rt;
    logic              wb_we;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic              hit_ex, hazard, stall, flush, hlt_ahead;
    logic [DATA_W-1:0] ex_a, ex_b, ex_res;
    logic              ex_taken;
    logic [DATA_W-1:0] mem_val;
    logic [31:0]       if_ir;

    // ID decode: illegal opcodes collapse to HLT, source/destination usage per class
    always_comb begin
        id_rs = ifid.ir[25:21];
        id_rt = ifid.ir[20:16];
        id_rd = ifid.ir[15:11];
        id_op = OP_HLT;
        case (ifid.ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
            OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_SLTI,
            OP_BNEQZ, OP_BEQZ: id_op = ifid.ir[31:26];
            default:           id_op = OP_HLT;
        endcase
        id_is_rr  = (id_op <= OP_MUL);
        id_is_rm  = (id_op inside {OP_ADDI, OP_SUBI, OP_SLTI});
        id_use_rs = id_is_rr || id_is_rm || (id_op inside {OP_LW, OP_SW, OP_BNEQZ, OP_BEQZ});
        id_use_rt = id_is_rr || (id_op == OP_SW);
        id_dst    = id_is_rr ? id_rd : id_rt;
    end

    // Write-first register file read; R0 is hard-wired to zero
    assign wb_we = memwb.vld && memwb.wr;
    assign rf_a  = (id_rs == 5'd0) ? '0 : (wb_we && memwb.dst == id_rs) ? memwb.val : Reg[id_rs];
    assign rf_b  = (id_rt == 5'd0) ? '0 : (wb_we && memwb.dst == id_rt) ? memwb.val : Reg[id_rt];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : Reg[dbg_addr];

    // ID/EX payload built from the decoded instruction
    always_comb begin
        id_pkt     = '0;
        id_pkt.vld = ifid.vld;
        id_pkt.op  = id_op;
`ifdef FORWARDING_EN
        id_pkt.rs  = id_rs;
        id_pkt.rt  = id_rt;
`endif
        id_pkt.dst = id_dst;
        id_pkt.wr  = (id_is_rr || id_is_rm || id_op == OP_LW) && (id_dst != 5'd0);
        id_pkt.a   = rf_a;
        id_pkt.b   = rf_b;
        id_pkt.imm = {{(DATA_W-16){ifid.ir[15]}}, ifid.ir[15:0]};
        id_pkt.npc = ifid.npc;
    end

    // Dependence of the ID instruction on an older in-flight writer
    assign hit_ex = idex.vld && idex.wr &&
                    ((id_use_rs && idex.dst == id_rs) || (id_use_rt && idex.dst == id_rt));

`ifdef FORWARDING_EN
    // Only a load in EX cannot be bypassed in time
    assign hazard = hit_ex && (idex.op == OP_LW);

    // Youngest producer wins: EX/MEM before MEM/WB before the register file value
    assign ex_a = (exmem.vld && exmem.wr && exmem.dst == idex.rs) ? exmem.alu :
                  (memwb.vld && memwb.wr && memwb.dst == idex.rs) ? memwb.val : idex.a;
    assign ex_b = (exmem.vld && exmem.wr && exmem.dst == idex.rt) ? exmem.alu :
                  (memwb.vld && memwb.wr && memwb.dst == idex.rt) ? memwb.val : idex.b;
`else
    logic hit_mem;
    // Without bypass, wait until the producer reaches WB where write-first covers it
    assign hit_mem = exmem.vld && exmem.wr &&
                     ((id_use_rs && exmem.dst == id_rs) || (id_use_rt && exmem.dst == id_rt));
    assign hazard  = hit_ex || hit_mem;
    assign ex_a    = idex.a;
    assign ex_b    = idex.b;
`endif

    assign stall = ifid.vld && hazard;

    // EX: ALU, effective address and branch resolution
    always_comb begin
        ex_res   = '0;
        ex_taken = 1'b0;
        case (idex.op)
            OP_ADD:   ex_res = ex_a + ex_b;
            OP_SUB:   ex_res = ex_a - ex_b;
            OP_AND:   ex_res = ex_a & ex_b;
            OP_OR:    ex_res = ex_a | ex_b;
            OP_SLT:   ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
            OP_MUL:   ex_res = ex_a * ex_b;
            OP_LW,
            OP_SW,
            OP_ADDI:  ex_res = ex_a + idex.imm;
            OP_SUBI:  ex_res = ex_a - idex.imm;
            OP_SLTI:  ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(idex.imm))};
            OP_BNEQZ: ex_taken = (ex_a != '0);
            OP_BEQZ:  ex_taken = (ex_a == '0);
            default:  ex_res = '0;
        endcase
    end

    assign flush = idex.vld && ex_taken;

    // MEM: combinational load path; stores commit at the clock edge below
    assign mem_val = (exmem.op == OP_LW) ? Mem[exmem.alu[ADDR_W-1:0]] : exmem.alu;

    // Fetch stops issuing once an HLT has been decoded and is still in flight
    assign hlt_ahead = (ifid.vld  && id_op     == OP_HLT) ||
                       (idex.vld  && idex.op   == OP_HLT) ||
                       (exmem.vld && exmem.op  == OP_HLT) ||
                       (memwb.vld && memwb.op  == OP_HLT);

    assign if_ir = Mem[pc][31:0];

    // Pipeline, PC and counters: reset > halted freeze > flush > stall > advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            halted  <= 1'b0;
            retired <= '0;
            stalls  <= '0;
            ifid    <= '0;
            idex    <= '0;
            exmem   <= '0;
            memwb   <= '0;
        end else if (!halted) begin
            halted <= memwb.vld && (memwb.op == OP_HLT);
            if (memwb.vld && retired != '1)
                retired <= retired + CNT_W'(1);
            if (stall && !flush && stalls != '1)
                stalls <= stalls + CNT_W'(1);

            if (flush) begin
                pc   <= idex.npc + idex.imm[ADDR_W-1:0];
                ifid <= '0;
                idex <= '0;
            end else if (stall) begin
                idex <= '0;
            end else begin
                idex <= id_pkt;
                if (hlt_ahead) begin
                    ifid <= '0;
                end else begin
                    ifid.vld <= 1'b1;
                    ifid.ir  <= if_ir;
                    ifid.npc <= pc + ADDR_W'(1);
                    pc       <= pc + ADDR_W'(1);
                end
            end

            exmem.vld <= idex.vld;
            exmem.op  <= idex.op;
            exmem.dst <= idex.dst;
            exmem.wr  <= idex.wr;
            exmem.alu <= ex_res;
            exmem.b   <= ex_b;

            memwb.vld <= exmem.vld;
            memwb.op  <= exmem.op;
            memwb.dst <= exmem.dst;
            memwb.wr  <= exmem.wr;
            memwb.val <= mem_val;
        end
    end

    // Store commit; valid bits are cleared by reset, so no store fires while rst is high
    always @(posedge clk) begin
        if (!halted && exmem.vld && exmem.op == OP_SW)
            Mem[exmem.alu[ADDR_W-1:0]] <= exmem.b;
    end

    // Register writeback; R0 writes were already dropped at decode
    always @(posedge clk) begin
        if (!halted && wb_we)
            Reg[memwb.dst] <= memwb.val;
    end

endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// tb_pipe_mips32_fwd: directed programs for pipe_mips32_fwd with hand-computed results.
// Expected stall counts and HLT latency depend on FORWARDING_EN.
// Each run is bounded by a cycle budget; a missed halt counts as a failed check.
module tb_pipe_mips32_fwd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halted;
    logic [9:0]  pc;
    logic [15:0] retired;
    logic [15:0] stalls;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc;
    logic [31:0] v;
    logic [31:0] prog [$];
    logic [9:0]  pc_snap;

`ifdef FORWARDING_EN
    localparam int ST_DEP  = 0;
    localparam int ST_LU   = 1;
    localparam int ST_FACT = 1;
    localparam int LAT_DEP = 7;
`else
    localparam int ST_DEP  = 2;
    localparam int ST_LU   = 2;
    localparam int ST_FACT = 17;
    localparam int LAT_DEP = 9;
`endif

    localparam logic [31:0] HLT = 32'hFC00_0000;

    always #5 clk = ~clk;

    pipe_mips32_fwd dut (
        .clk      (clk),
        .rst      (rst),
        .halted   (halted),
        .pc       (pc),
        .retired  (retired),
        .stalls   (stalls),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    function automatic logic [31:0] rr(input int op, input int rd, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input int op, input int rt, input int rs, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold reset, clear memory, set Reg[k]=k, load the program at address 0
    task automatic init();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.Reg[i] = 32'(i);
        foreach (prog[i]) dut.Mem[i] = prog[i];
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(output int n);
        n = 0;
        while (!halted && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic rdreg(input logic [4:0] idx, output logic [31:0] val);
        dbg_addr = idx;
        #1;
        val = dbg_data;
    endtask

    initial begin
        // Dependent ALU ops, plus reset-state checks
        prog = '{rr(0, 3, 1, 2), rr(0, 4, 3, 3), HLT};
        init();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_stalls", 32'(stalls), 32'd0);
        release_rst();
        run_to_halt(cyc);
        check("dep_latency", 32'(cyc), 32'(LAT_DEP));
        rdreg(5'd4, v);
        check("dep_r4", v, 32'd6);
        rdreg(5'd3, v);
        check("dep_r3", v, 32'd3);
        check("dep_retired", 32'(retired), 32'd3);
        check("dep_stalls", 32'(stalls), 32'(ST_DEP));
        check("dep_pc", 32'(pc), 32'd3);

        // Load-use
        prog = '{ri(8, 2, 10, 0), rr(0, 3, 2, 2), HLT};
        init();
        dut.Mem[200] = 32'd7;
        dut.Reg[10]  = 32'd200;
        release_rst();
        run_to_halt(cyc);
        rdreg(5'd3, v);
        check("lu_r3", v, 32'd14);
        check("lu_stalls", 32'(stalls), 32'(ST_LU));
        check("lu_retired", 32'(retired), 32'd3);

        // Factorial loop
        prog = '{ri(10, 10, 0, 200), ri(10, 2, 0, 1), ri(8, 3, 10, 0), rr(5, 2, 2, 3),
                 ri(11, 3, 3, 1), ri(13, 0, 3, -3), ri(9, 2, 10, -2), HLT};
        init();
        dut.Mem[200] = 32'd7;
        release_rst();
        run_to_halt(cyc);
        check("fact_mem198", dut.Mem[198], 32'd5040);
        rdreg(5'd3, v);
        check("fact_r3", v, 32'd0);
        rdreg(5'd2, v);
        check("fact_r2", v, 32'd5040);
        check("fact_retired", 32'(retired), 32'd26);
        check("fact_stalls", 32'(stalls), 32'(ST_FACT));

        // Branch flush: BEQZ on R0 skips both ADDI R5
        prog = '{ri(14, 0, 0, 2), ri(10, 5, 0, 9), ri(10, 5, 0, 9), ri(10, 6, 0, 3), HLT};
        init();
        release_rst();
        run_to_halt(cyc);
        rdreg(5'd5, v);
        check("br_r5", v, 32'd5);
        rdreg(5'd6, v);
        check("br_r6", v, 32'd3);
        check("br_retired", 32'(retired), 32'd3);

        // Reset in the middle of the factorial loop, then rerun
        prog = '{ri(10, 10, 0, 200), ri(10, 2, 0, 1), ri(8, 3, 10, 0), rr(5, 2, 2, 3),
                 ri(11, 3, 3, 1), ri(13, 0, 3, -3), ri(9, 2, 10, -2), HLT};
        init();
        dut.Mem[200] = 32'd7;
        release_rst();
        repeat (15) @(negedge clk);
        check("mid_retired_nonzero", 32'(retired != 16'd0), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_retired", 32'(retired), 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd0);
        init();
        dut.Mem[200] = 32'd7;
        release_rst();
        run_to_halt(cyc);
        check("mid_rerun_mem198", dut.Mem[198], 32'd5040);

        // R0 discard and illegal opcode acting as HLT
        prog = '{ri(10, 0, 0, 5), {6'b010101, 26'd0}};
        init();
        dut.Reg[0] = 32'hDEAD_BEEF;
        release_rst();
        run_to_halt(cyc);
        rdreg(5'd0, v);
        check("r0_dbg", v, 32'd0);
        check("r0_array_untouched", dut.Reg[0], 32'hDEAD_BEEF);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_retired", 32'(retired), 32'd2);
        check("ill_pc", 32'(pc), 32'd2);
        pc_snap = pc;
        repeat (5) @(negedge clk);
        check("freeze_retired", 32'(retired), 32'd2);
        check("freeze_pc", 32'(pc), 32'(pc_snap));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
